// File: rtl/float_to_fixed.sv
// float_to_fixed
// Sequential IEEE-754 single-precision unpacker. Splits a float into a
// two's-complement integer mantissa and a signed exponent such that
// value = fixed_out * 2^exp_out. The result is canonical: the mantissa is
// odd (trailing zeros stripped), or zero. Normalisation runs one bit per
// clock.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   float_in   IEEE-754 single operand, captured when load_new is seen in IDLE
//   load_new   start request (ignored while busy)
//   fixed_out  signed integer mantissa result
//   exp_out    signed exponent result
//   busy       conversion in progress
//   done       one-cycle pulse when results update
//   inexact    set bits were dropped by underflow shifting
//   invalid    input was Inf or NaN
module float_to_fixed (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] float_in,
    input  logic        load_new,
    output logic [31:0] fixed_out,
    output logic [7:0]  exp_out,
    output logic        busy,
    output logic        done,
    output logic        inexact,
    output logic        invalid
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_q, state_d;
    logic [23:0]        m_q, m_d;        // working magnitude
    logic signed [8:0]  x_q, x_d;        // working exponent, wide enough for -149
    logic               sign_q, sign_d;
    logic               inv_q, inv_d;    // operand was Inf/NaN
    logic               inx_q, inx_d;    // a set bit has been shifted out
    logic [31:0]        fixed_q, fixed_d;
    logic [7:0]         exp_q, exp_d;
    logic               done_q, done_d;
    logic               inexact_q, inexact_d;
    logic               invalid_q, invalid_d;

    logic [7:0]         f_exp;
    logic [22:0]        f_frac;
    logic               shift_go;

    assign f_exp  = float_in[30:23];
    assign f_frac = float_in[22:0];

    // Keep shifting while bits remain and either the mantissa is even or the
    // exponent is still below what an 8-bit exponent can represent.
    assign shift_go = (m_q != 24'd0) && (!m_q[0] || (x_q < -9'sd128));

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        x_d       = x_q;
        sign_d    = sign_q;
        inv_d     = inv_q;
        inx_d     = inx_q;
        fixed_d   = fixed_q;
        exp_d     = exp_q;
        done_d    = 1'b0;
        inexact_d = inexact_q;
        invalid_d = invalid_q;

        case (state_q)
            IDLE: begin
                if (load_new) begin
                    state_d = SHIFT;
                    sign_d  = float_in[31];
                    inx_d   = 1'b0;
                    inv_d   = 1'b0;
                    if (f_exp == 8'hFF) begin
                        inv_d = 1'b1;
                        m_d   = 24'd0;
                        x_d   = 9'sd0;
                    end else if (f_exp == 8'h00) begin
                        // Denormal or zero; zero gets M=0 and X=0.
                        m_d = {1'b0, f_frac};
                        x_d = (f_frac == 23'd0) ? 9'sd0 : -9'sd149;
                    end else begin
                        m_d = {1'b1, f_frac};
                        x_d = $signed({1'b0, f_exp}) - 9'sd150;
                    end
                end
            end
            SHIFT: begin
                if (shift_go) begin
                    m_d = m_q >> 1;
                    x_d = x_q + 9'sd1;
                    if (m_q[0]) inx_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (inv_q) begin
                        fixed_d   = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
                        exp_d     = 8'd127;
                        invalid_d = 1'b1;
                        inexact_d = 1'b0;
                    end else if (m_q == 24'd0) begin
                        // True zero or underflow flushed to zero; sign is lost.
                        fixed_d   = 32'd0;
                        exp_d     = 8'd0;
                        invalid_d = 1'b0;
                        inexact_d = inx_q;
                    end else begin
                        fixed_d   = sign_q ? (32'd0 - {8'd0, m_q}) : {8'd0, m_q};
                        exp_d     = x_q[7:0];
                        invalid_d = 1'b0;
                        inexact_d = inx_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            m_q       <= 24'd0;
            x_q       <= 9'sd0;
            sign_q    <= 1'b0;
            inv_q     <= 1'b0;
            inx_q     <= 1'b0;
            fixed_q   <= 32'd0;
            exp_q     <= 8'd0;
            done_q    <= 1'b0;
            inexact_q <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            x_q       <= x_d;
            sign_q    <= sign_d;
            inv_q     <= inv_d;
            inx_q     <= inx_d;
            fixed_q   <= fixed_d;
            exp_q     <= exp_d;
            done_q    <= done_d;
            inexact_q <= inexact_d;
            invalid_q <= invalid_d;
        end
    end

    assign fixed_out = fixed_q;
    assign exp_out   = exp_q;
    assign busy      = (state_q == SHIFT);
    assign done      = done_q;
    assign inexact   = inexact_q;
    assign invalid   = invalid_q;

endmodule
